// File: rtl/inst_fetch_queue_pkg.sv
// Shared opcode constants and fetch FSM state type for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_MEM,
    DROP
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_fetch_predecode.sv
// Combinational control-flow predecode: classifies a fetched word and extracts J/B immediates.
module fetch_predecode
  import inst_fetch_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        is_jal_o,
  output logic        is_br_o,
  output logic        is_jalr_o,
  output logic [31:0] imm_j_o,
  output logic [31:0] imm_b_o
);

  assign is_jal_o  = (inst_i[6:0] == OP_JAL);
  assign is_br_o   = (inst_i[6:0] == OP_BRANCH);
  assign is_jalr_o = (inst_i[6:0] == OP_JALR);

  assign imm_j_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_b_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: PC generation, icache lookup with memctrl fallback, BHT-guided
// predecode and a DEPTH-entry dispatch queue with stale-response drop after flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned PTR_W     = $clog2(DEPTH),
  parameter int unsigned BHT_IDX_W = 12,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  output logic [31:0]          ic_addr,
  input  logic                 ic_hit,
  input  logic [31:0]          ic_inst,
  output logic                 ic_fill_en,
  output logic [31:0]          ic_fill_addr,
  output logic [31:0]          ic_fill_data,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_inst,
  output logic [BHT_IDX_W-1:0] bht_idx,
  input  logic                 bht_taken,
  output logic                 dq_valid,
  input  logic                 dq_ready,
  output logic [31:0]          dq_inst,
  output logic [31:0]          dq_pc,
  output logic [31:0]          dq_pred_pc,
  output logic                 dq_pred_taken,
  output logic [PTR_W:0]       count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;

  logic [31:0] inst_q    [DEPTH];
  logic [31:0] pc_mem_q  [DEPTH];
  logic [31:0] pred_pc_q [DEPTH];
  logic        taken_q   [DEPTH];

  logic        push_en, pop_en, full;
  logic [31:0] push_word, pc_plus4, pred_pc, next_pc;
  logic        pred_taken;
  logic        is_jal, is_br, is_jalr;
  logic [31:0] imm_j, imm_b;

  // The pushed word comes from the icache in FETCH and from memctrl otherwise.
  assign push_word = (state_q == FETCH) ? ic_inst : mem_inst;
  assign full      = (count_q == (PTR_W + 1)'(DEPTH));
  assign dq_valid  = (count_q != '0);
  assign pc_plus4  = pc_q + 32'd4;

  fetch_predecode u_predecode (
    .inst_i    (push_word),
    .is_jal_o  (is_jal),
    .is_br_o   (is_br),
    .is_jalr_o (is_jalr),
    .imm_j_o   (imm_j),
    .imm_b_o   (imm_b)
  );

  always_comb begin
    pred_pc    = pc_plus4;
    pred_taken = 1'b0;
    unique case ({is_jal, is_br, is_jalr})
      3'b100: begin
        pred_pc    = pc_q + imm_j;
        pred_taken = 1'b1;
      end
      3'b010: begin
        pred_pc    = pc_q + imm_b;
        pred_taken = bht_taken;
      end
      default: begin
        pred_pc    = pc_plus4;
        pred_taken = 1'b0;
      end
    endcase
    next_pc = pred_taken ? pred_pc : pc_plus4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    if (rdy) begin
      pop_en = dq_valid && dq_ready && !flush;
      unique case (state_q)
        FETCH: begin
          if (!flush && !full) begin
            if (ic_hit) begin
              push_en = 1'b1;
            end else begin
              mem_addr_d = pc_q;
              mem_req_d  = 1'b1;
              state_d    = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ready) begin
            push_en   = !flush;
            mem_req_d = 1'b0;
            state_d   = FETCH;
          end else if (flush) begin
            state_d = DROP;
          end
        end
        DROP: begin
          if (mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase

      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = flush_pc;
      end else begin
        if (push_en) begin
          pc_d   = next_pc;
          tail_d = tail_q + PTR_W'(1);
        end
        if (pop_en) begin
          head_d = head_q + PTR_W'(1);
        end
        unique case ({push_en, pop_en})
          2'b10:   count_d = count_q + (PTR_W + 1)'(1);
          2'b01:   count_d = count_q - (PTR_W + 1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      inst_q[tail_q]    <= push_word;
      pc_mem_q[tail_q]  <= pc_q;
      pred_pc_q[tail_q] <= pred_pc;
      taken_q[tail_q]   <= pred_taken;
    end
  end

  // Fill on every memctrl response, including ones discarded after a flush.
  assign ic_fill_en   = rdy && mem_ready && (state_q != FETCH);
  assign ic_fill_addr = ic_fill_en ? mem_addr_q : '0;
  assign ic_fill_data = ic_fill_en ? mem_inst : '0;

  assign ic_addr  = pc_q;
  assign bht_idx  = pc_q[BHT_IDX_W+1:2];
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign count    = count_q;

  assign dq_inst       = dq_valid ? inst_q[head_q]    : '0;
  assign dq_pc         = dq_valid ? pc_mem_q[head_q]  : '0;
  assign dq_pred_pc    = dq_valid ? pred_pc_q[head_q] : '0;
  assign dq_pred_taken = dq_valid ? taken_q[head_q]   : 1'b0;

endmodule
